p_fxp_acc: RTL
==============

P_FXP_ACC -- requirements
Module: p_fxp_acc

Interface
REQ-001 Parameter IN_PREC, default 16, width of the signed fixed-point product arriving from the multiplier stage.
REQ-002 Parameter ACC_PREC, default 24, width of the internal signed accumulator; ACC_PREC >= IN_PREC + 1 SHALL hold.
REQ-003 Parameter OUT_PREC, default 16, width of the signed result; OUT_PREC <= ACC_PREC SHALL hold.
REQ-004 Parameter NUM, default 4, number of products per dot product (>= 1).
REQ-005 One clock and one reset: clk, and reset_, which is synchronous and active-low.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 reset_  input  1  synchronous active-low reset.
REQ-008 in_valid  input  1  a product is presented on in.
REQ-009 in_ready  output  1  the block accepts in this cycle.
REQ-010 in  input  IN_PREC  signed product, same fraction position as the accumulator.
REQ-011 in_ovf  input  1  overflow flag from the multiplier for this product.
REQ-012 in_udf  input  1  underflow flag from the multiplier for this product.
REQ-013 bias  input  ACC_PREC  signed bias, sampled with the first product of each vector.
REQ-014 out_valid  output  1  result held on out.
REQ-015 out_ready  input  1  downstream accepts the result.
REQ-016 out  output  OUT_PREC  signed saturated dot-product result.
REQ-017 ovf  output  1  sticky overflow/saturation flag for the current result.
REQ-018 udf  output  1  sticky underflow flag for the current result.

Function
REQ-019 Two states SHALL exist: ACC (collecting products) and OUT (holding the result); in_ready = (state==ACC), out_valid = (state==OUT).
REQ-020 A product SHALL be accepted in any cycle where in_valid && in_ready; a 0..NUM-1 term counter SHALL track accepted products.
REQ-021 Term 0: acc <= sat(sext(bias) + sext(in)); term k>0: acc <= sat(acc + sext(in)); all sums use ACC_PREC+1 bits before saturation.
REQ-022 Accumulator saturation SHALL clamp to +(2^(ACC_PREC-1)-1) / -2^(ACC_PREC-1) and set ovf.
REQ-023 On acceptance of term NUM-1, the block SHALL move to OUT in the next cycle, reset the counter to 0, and drive out = acc narrowed to OUT_PREC with saturation; narrowing saturation sets ovf.
REQ-024 Latency: out_valid SHALL rise exactly one cycle after the clock edge that accepts the final term; throughput is at most one result per NUM+1 cycles.
REQ-025 In OUT, out, ovf, and udf SHALL be held stable until out_valid && out_ready; on that edge the state SHALL return to ACC.
REQ-026 No product is accepted in OUT (in_ready=0), regardless of in_valid.
REQ-027 ovf SHALL be the OR of in_ovf over accepted terms, accumulator saturation, and output saturation; udf SHALL be the OR of in_udf over accepted terms.
REQ-028 ovf and udf SHALL be cleared on acceptance of term 0 of the next vector, with term 0's own flags then applied.
REQ-029 With NUM=1, each accepted product SHALL produce a result (bias + in) in the next cycle.

Reset
REQ-030 While reset_ is low at a rising edge: state=ACC, counter=0, acc=0, out=0, ovf=0, udf=0, out_valid=0.
REQ-031 in_ready SHALL be 0 in any cycle where reset_ is low, and 1 in the first cycle after the reset is released.
REQ-032 A reset in the middle of a vector SHALL discard partial terms; the next accepted product is term 0.

Verification (NUM=4, IN_PREC=16, ACC_PREC=24, OUT_PREC=16)
REQ-033 bias=10, terms 1,2,3,4 back-to-back -> out=20, ovf=udf=0, out_valid one cycle after the 4th accept.
REQ-034 bias=0, terms -100,50,-25,0 -> out=-75 (0xFFB5), flags 0.
REQ-035 bias=0, four terms 0x7FFF -> acc=131068, out=0x7FFF, ovf=1; next vector 1,1,1,1 -> out=4, ovf=0.
REQ-036 bias=8388600, term 0x7FFF, then 0,0,0 -> acc clamps to 0x7FFFFF, out=0x7FFF, ovf=1.
REQ-037 Result ready, out_ready held low 3 cycles with in_valid=1 -> out stable, in_ready=0, no terms consumed; accepted on the 4th cycle.
REQ-038 Two terms accepted, reset_ low 1 cycle, then bias=0, terms 5,5,5,5 -> out=20; in_udf=1 on one term -> udf=1 on that result only.

Source files
------------

// File: rtl/p_fxp_acc.sv
// p_fxp_acc: signed fixed-point dot-product accumulator.
// Collects NUM products (the first one added to a bias), saturating the running
// sum at ACC_PREC bits, then presents the sum narrowed to OUT_PREC bits with
// saturation. Sticky overflow/underflow flags travel with each result.
module p_fxp_acc #(
   parameter int IN_PREC  = 16,
   parameter int ACC_PREC = 24,
   parameter int OUT_PREC = 16,
   parameter int NUM      = 4
) (
   input  logic                clk,
   input  logic                reset_,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [IN_PREC-1:0]  in,
   input  logic                in_ovf,
   input  logic                in_udf,
   input  logic [ACC_PREC-1:0] bias,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [OUT_PREC-1:0] out,
   output logic                ovf,
   output logic                udf
);

   localparam int CNT_W = (NUM > 1) ? $clog2(NUM) : 1;

   localparam logic [ACC_PREC-1:0] ACC_MAXV = {1'b0, {(ACC_PREC-1){1'b1}}};
   localparam logic [ACC_PREC-1:0] ACC_MINV = {1'b1, {(ACC_PREC-1){1'b0}}};
   localparam logic [OUT_PREC-1:0] OUT_MAXV = {1'b0, {(OUT_PREC-1){1'b1}}};
   localparam logic [OUT_PREC-1:0] OUT_MINV = {1'b1, {(OUT_PREC-1){1'b0}}};

   typedef enum logic {
      S_ACC = 1'b0,
      S_OUT = 1'b1
   } state_t;

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic [ACC_PREC-1:0] acc;

   logic                first_term;
   logic                last_term;
   logic                accept;
   logic [ACC_PREC:0]   addend;
   logic [ACC_PREC:0]   in_ext;
   logic [ACC_PREC:0]   sum_wide;
   logic                acc_sat;
   logic [ACC_PREC-1:0] acc_next;
   logic [ACC_PREC-OUT_PREC:0] upper_bits;
   logic                out_sat;
   logic [OUT_PREC-1:0] out_next;

   // Handshake outputs; reset forces in_ready low even before the state settles.
   assign in_ready   = reset_ && (state == S_ACC);
   assign out_valid  = (state == S_OUT);
   assign accept     = in_valid && in_ready;
   assign first_term = (cnt == '0);
   assign last_term  = (cnt == CNT_W'(NUM - 1));

   // Next accumulator value: one guard bit catches overflow, which clamps to the rail
   // matching the true sign (the guard bit), then the narrowed output is derived from it.
   always_comb begin
      addend   = first_term ? {bias[ACC_PREC-1], bias} : {acc[ACC_PREC-1], acc};
      in_ext   = {{(ACC_PREC + 1 - IN_PREC){in[IN_PREC-1]}}, in};
      sum_wide = addend + in_ext;
      acc_sat  = (sum_wide[ACC_PREC] != sum_wide[ACC_PREC-1]);
      acc_next = sum_wide[ACC_PREC-1:0];
      if (acc_sat) begin
         acc_next = sum_wide[ACC_PREC] ? ACC_MINV : ACC_MAXV;
      end
      upper_bits = acc_next[ACC_PREC-1:OUT_PREC-1];
      out_sat    = !((&upper_bits) || !(|upper_bits));
      out_next   = acc_next[OUT_PREC-1:0];
      if (out_sat) begin
         out_next = acc_next[ACC_PREC-1] ? OUT_MINV : OUT_MAXV;
      end
   end

   // Two-state controller: accumulate terms in S_ACC, hold the result in S_OUT
   // until the consumer takes it. Flags restart with term 0 of each vector.
   always_ff @(posedge clk) begin
      if (!reset_) begin
         state <= S_ACC;
         cnt   <= '0;
         acc   <= '0;
         out   <= '0;
         ovf   <= 1'b0;
         udf   <= 1'b0;
      end else begin
         case (state)
            S_ACC: begin
               if (accept) begin
                  acc <= acc_next;
                  ovf <= (ovf && !first_term) || in_ovf || acc_sat || (last_term && out_sat);
                  udf <= (udf && !first_term) || in_udf;
                  if (last_term) begin
                     cnt   <= '0;
                     out   <= out_next;
                     state <= S_OUT;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end
            S_OUT: begin
               if (out_ready) begin
                  state <= S_ACC;
               end
            end
            default: state <= S_ACC;
         endcase
      end
   end

endmodule
